// File: rtl/sum_sq_pkg.sv
// Shared definitions for the sum-of-squares radicand front end.
//   IN_W    : operand width; each operand multiply takes IN_W cycles
//   RAD_W   : radicand width presented to the sqrt stage
//   ACC_W   : accumulator width, wide enough for (2^IN_W-1)^2 * 2
//   RAD_MAX : largest radicand representable in RAD_W bits
//   CNT_W   : width of the per-operand bit counter
//   state_t : sequencing FSM states
package sum_sq_pkg;

  localparam int unsigned IN_W    = 4;
  localparam int unsigned RAD_W   = 8;
  localparam int unsigned ACC_W   = 2 * IN_W + 1;
  localparam int unsigned RAD_MAX = (1 << RAD_W) - 1;
  localparam int unsigned CNT_W   = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cla_add9.sv
// Combinational carry-lookahead adder, ACC_W bits wide (9 at defaults).
// Ports:
//   a, b : unsigned addends
//   sum  : a + b, truncated to ACC_W bits (carry-out is never needed
//          because the accumulator is sized to hold the largest x^2+y^2)
// Every carry is formed directly from generate/propagate terms of the
// lower bits, so no carry depends on another carry.
module cla_add9
  import sum_sq_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] g;
  logic [ACC_W-1:0] p;
  logic [ACC_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... ; carry-in is 0
  always_comb begin
    logic prop;
    c = '0;
    for (int unsigned i = 0; i < ACC_W; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int unsigned k = 1; k <= i; k++) begin
        c[i+1] = c[i+1] | (prop & g[i-k]);
        prop   = prop & p[i-k];
      end
    end
  end

  assign sum = p ^ c[ACC_W-1:0];

endmodule

// File: rtl/sum_sq_feeder.sv
// Sequential x^2 + y^2 front end for the integer square-root stage.
// Each operand is squared by shift-and-add through one shared
// carry-lookahead adder (IN_W cycles per operand), then the radicand is
// held with a level out_valid until the consumer acknowledges it.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : operand pair present        in_ready  : block idle, can accept
//   x, y      : unsigned operands (IN_W)
//   out_valid : radicand valid (sqrt enable) out_ready : consumer acknowledge
//   radicand  : x^2 + y^2 (RAD_W)           overflow  : true sum > RAD_MAX
// Build option: define SUMSQ_SAT_EN to saturate the radicand to all ones
// on overflow; otherwise the radicand wraps modulo 2^RAD_W.
module sum_sq_feeder
  import sum_sq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RAD_W-1:0] radicand,
  output logic             overflow
);

  state_t state;
  state_t state_next;

  logic [IN_W-1:0]  x_q;
  logic [IN_W-1:0]  y_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [IN_W-1:0]  operand;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_sum;
  logic             last_bit;
  logic             sum_ovf;
  logic [RAD_W-1:0] sum_rad;

  assign last_bit = (cnt == CNT_W'(IN_W - 1));
  assign in_ready = (state == IDLE);

  // Partial product for the current bit of the operand being squared
  always_comb begin
    operand = (state == MUL_Y) ? y_q : x_q;
    addend  = '0;
    if ((state == MUL_X || state == MUL_Y) && operand[cnt])
      addend = ACC_W'(operand) << cnt;
  end

  cla_add9 u_add (
    .a   (acc),
    .b   (addend),
    .sum (acc_sum)
  );

  // Output value is formed from the final adder result so the radicand
  // is registered on the same edge as the last accumulation.
  assign sum_ovf = |acc_sum[ACC_W-1:RAD_W];
`ifdef SUMSQ_SAT_EN
  assign sum_rad = sum_ovf ? '1 : acc_sum[RAD_W-1:0];
`else
  assign sum_rad = acc_sum[RAD_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (in_valid)  state_next = MUL_X;
      MUL_X: if (last_bit)  state_next = MUL_Y;
      MUL_Y: if (last_bit)  state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      radicand  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q <= x;
            y_q <= y;
            acc <= '0;
            cnt <= '0;
          end
        end
        MUL_X: begin
          acc <= acc_sum;
          cnt <= last_bit ? '0 : cnt + 1'b1;
        end
        MUL_Y: begin
          acc <= acc_sum;
          cnt <= last_bit ? '0 : cnt + 1'b1;
          if (last_bit) begin
            radicand  <= sum_rad;
            overflow  <= sum_ovf;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_sq_feeder.sv
module tb_sum_sq_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic [3:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] radicand;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  sum_sq_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .radicand  (radicand),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vx;
    int vy;
    int rad;
    int ovf;
  } vec_t;

  vec_t vecs[7];

`ifdef SUMSQ_SAT_EN
  localparam int R_15_15 = 255;
  localparam int R_15_6  = 255;
`else
  localparam int R_15_15 = 194;
  localparam int R_15_6  = 5;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Present a pair, return edges from acceptance until out_valid (-1 on timeout)
  task automatic start_pair(input int vx, input int vy, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    x = 4'(vx);
    y = 4'(vy);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_busy", int'(in_ready), 0);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_ack", int'(out_valid), 0);
    chk("in_ready_after_ack", int'(in_ready), 1);
  endtask

  initial begin
    int lat;

    vecs[0] = '{3, 4, 25, 0};
    vecs[1] = '{15, 15, R_15_15, 1};
    vecs[2] = '{11, 11, 242, 0};
    vecs[3] = '{15, 6, R_15_6, 1};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{1, 1, 2, 0};
    vecs[6] = '{7, 9, 130, 0};

    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_radicand", int'(radicand), 0);
    chk("reset_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      start_pair(vecs[i].vx, vecs[i].vy, lat);
      chk($sformatf("latency_v%0d", i), lat, 8);
      chk($sformatf("radicand_v%0d", i), int'(radicand), vecs[i].rad);
      chk($sformatf("overflow_v%0d", i), int'(overflow), vecs[i].ovf);
      if (i == 0) chk("sqrt_root_3_4", isqrt(int'(radicand)), 5);
      ack();
    end

    // Backpressure: hold DONE, ignore a concurrent pair
    start_pair(5, 3, lat);
    chk("bp_latency", lat, 8);
    @(negedge clk);
    in_valid = 1'b1;
    x = 4'd1;
    y = 4'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_radicand", int'(radicand), 34);
      chk("bp_overflow", int'(overflow), 0);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ack();
    start_pair(6, 7, lat);
    chk("post_bp_latency", lat, 8);
    chk("post_bp_radicand", int'(radicand), 85);
    chk("post_bp_overflow", int'(overflow), 0);
    ack();

    // Reset during MUL_Y (edges E5..E8 accumulate y)
    @(negedge clk);
    in_valid = 1'b1;
    x = 4'd15;
    y = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_radicand", int'(radicand), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    start_pair(2, 2, lat);
    chk("after_rst_latency", lat, 8);
    chk("after_rst_radicand", int'(radicand), 8);
    chk("after_rst_overflow", int'(overflow), 0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
